// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter
//   Round-robin write arbiter and sequencer for a shared falling-edge register.
//   Grants are registered on the rising edge. The register commits reg_data on
//   the falling edge of the same cycle. A requester that also raises its lock
//   bit keeps the grant for a burst of up to MAX_HOLD cycles. A burst that
//   reaches that length is followed by one idle GAP cycle.
//
// Ports
//   clock           system clock, all state on the rising edge
//   ctrl_reset_n    asynchronous active-low reset
//   req[i]          requester i wants to write, held until ack[i]
//   lock[i]         requester i asks to keep the grant (only the winner's bit matters)
//   data_in         packed write data, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   grant / ack     registered one-hot grant (ack is identical)
//   reg_writeEnable write enable to the register, OR of grant
//   reg_data        registered winner data, holds its value when nothing is granted
//   busy            high in GRANT or LOCKED
//   write_count     committed writes, wraps at 16 bits
module reg_write_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 32,
   parameter int MAX_HOLD   = 8
) (
   input  logic                          clock,
   input  logic                          ctrl_reset_n,
   input  logic [NUM_REQ-1:0]            req,
   input  logic [NUM_REQ-1:0]            lock,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] data_in,
   output logic [NUM_REQ-1:0]            grant,
   output logic [NUM_REQ-1:0]            ack,
   output logic                          reg_writeEnable,
   output logic [DATA_WIDTH-1:0]         reg_data,
   output logic                          busy,
   output logic [15:0]                   write_count
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam logic [7:0] HOLD_MAX = 8'(MAX_HOLD);

   typedef logic [IDX_W-1:0] idx_t;
   typedef enum logic [1:0] {IDLE, GRANT, LOCKED, GAP} state_t;

   state_t                 state, state_nxt;
   idx_t                   ptr, ptr_nxt;
   idx_t                   owner, owner_nxt;      // requester holding the current grant/burst
   logic [7:0]             hold_cnt, hold_nxt;
   logic [NUM_REQ-1:0]     grant_nxt;
   logic [DATA_WIDTH-1:0]  data_nxt;

   logic [DATA_WIDTH-1:0]  lane_data [NUM_REQ];
   logic                   win_found;
   idx_t                   win_idx;
   idx_t                   win_next;
   logic                   burst_on;

   // Unpack the flat data bus into one word per requester.
   for (genvar g = 0; g < NUM_REQ; g++) begin : g_lane
      assign lane_data[g] = data_in[g*DATA_WIDTH +: DATA_WIDTH];
   end

   // Round-robin search: first requester at or after ptr, wrapping.
   always_comb begin
      int j;
      j         = 0;
      win_found = 1'b0;
      win_idx   = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         j = (int'(ptr) + k) % NUM_REQ;
         if (!win_found && req[j]) begin
            win_found = 1'b1;
            win_idx   = idx_t'(j);
         end
      end
      win_next = (win_idx == idx_t'(NUM_REQ-1)) ? '0 : win_idx + 1'b1;
   end

   // The burst continues only while the owner keeps both req and lock.
   assign burst_on = (state == LOCKED) && req[owner] && lock[owner];

   always_comb begin
      state_nxt = IDLE;
      grant_nxt = '0;
      data_nxt  = reg_data;
      ptr_nxt   = ptr;
      owner_nxt = owner;
      hold_nxt  = hold_cnt;
      if (burst_on) begin
         if (hold_cnt < HOLD_MAX) begin
            state_nxt        = LOCKED;
            grant_nxt[owner] = 1'b1;
            data_nxt         = lane_data[owner];
            hold_nxt         = hold_cnt + 8'd1;
         end else begin
            // Burst length exhausted: one dead cycle. ptr already points
            // past the owner, so the next arbitration favours the others.
            state_nxt = GAP;
         end
      end else if (win_found) begin
         // IDLE, GRANT, GAP and a broken burst all arbitrate identically.
         state_nxt          = lock[win_idx] ? LOCKED : GRANT;
         grant_nxt[win_idx] = 1'b1;
         data_nxt           = lane_data[win_idx];
         ptr_nxt            = win_next;
         owner_nxt          = win_idx;
         hold_nxt           = 8'd1;
      end
   end

   always_ff @(posedge clock or negedge ctrl_reset_n) begin
      if (!ctrl_reset_n) begin
         state       <= IDLE;
         ptr         <= '0;
         owner       <= '0;
         hold_cnt    <= '0;
         grant       <= '0;
         reg_data    <= '0;
         write_count <= '0;
      end else begin
         state    <= state_nxt;
         ptr      <= ptr_nxt;
         owner    <= owner_nxt;
         hold_cnt <= hold_nxt;
         grant    <= grant_nxt;
         reg_data <= data_nxt;
         // The write of the cycle now ending was committed at its falling edge.
         if (reg_writeEnable) write_count <= write_count + 16'd1;
      end
   end

   assign ack             = grant;
   assign reg_writeEnable = |grant;
   assign busy            = (state == GRANT) || (state == LOCKED);

endmodule

// File: tb/tb_reg_write_arbiter.sv
module tb_reg_write_arbiter;
   localparam int N  = 4;
   localparam int DW = 32;
   localparam int MH = 8;

   logic            clock = 1'b0;
   logic            ctrl_reset_n = 1'b0;
   logic [N-1:0]    req = '0;
   logic [N-1:0]    lock = '0;
   logic [N*DW-1:0] data_in = '0;
   logic [N-1:0]    grant, ack;
   logic            reg_writeEnable, busy;
   logic [DW-1:0]   reg_data;
   logic [15:0]     write_count;

   always #5 clock = ~clock;

   reg_write_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .MAX_HOLD(MH)) dut (
      .clock(clock), .ctrl_reset_n(ctrl_reset_n), .req(req), .lock(lock),
      .data_in(data_in), .grant(grant), .ack(ack), .reg_writeEnable(reg_writeEnable),
      .reg_data(reg_data), .busy(busy), .write_count(write_count));

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;

   typedef struct {
      int            cyc;
      logic [N-1:0]  g;
      logic [DW-1:0] d;
      logic [15:0]   wc;
   } exp_t;
   exp_t sbq[$];
   exp_t mon_e;

   logic [DW-1:0] d [N];
   logic [DW-1:0] shadow = '0;   // stand-in for the falling-edge register

   // Reference model: who writes in which cycle, from the arbitration rules.
   int m_ptr, m_owner, m_hold, m_last, m_wc;
   bit m_burst;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic void model_reset();
      m_ptr = 0; m_owner = 0; m_hold = 0; m_last = -1; m_wc = 0; m_burst = 0;
      sbq.delete();
   endfunction

   function automatic void push(input int w);
      exp_t e;
      e.cyc = cyc;
      e.g = '0;
      e.g[w] = 1'b1;
      e.d = d[w];
      e.wc = 16'(m_wc);
      m_wc++;
      sbq.push_back(e);
      m_last = w;
   endfunction

   function automatic void model_step();
      int j;
      m_last = -1;
      if (m_burst && req[m_owner] && lock[m_owner]) begin
         if (m_hold < MH) begin
            m_hold++;
            push(m_owner);
         end else begin
            m_burst = 0;          // dead cycle, then fresh arbitration
         end
         return;
      end
      m_burst = 0;
      for (int k = 0; k < N; k++) begin
         j = (m_ptr + k) % N;
         if (req[j]) begin
            push(j);
            m_ptr = (j + 1) % N;
            m_owner = j;
            m_hold = 1;
            m_burst = lock[j];
            return;
         end
      end
   endfunction

   task automatic drive();
      for (int i = 0; i < N; i++) data_in[i*DW +: DW] = d[i];
   endtask

   // One rising edge: the model sees the inputs the DUT sees, then inputs may change.
   task automatic cycle();
      @(posedge clock);
      cyc++;
      if (ctrl_reset_n) model_step();
      else m_last = -1;
      #1;
   endtask

   task automatic do_reset();
      ctrl_reset_n = 1'b0;
      model_reset();
      cycle();
      cycle();
      ctrl_reset_n = 1'b1;
   endtask

   task automatic drain();
      req = '0; lock = '0;
      repeat (3) cycle();
   endtask

   // Monitor: every cycle with a write must match the next scoreboard entry.
   always @(negedge clock) begin
      if (reg_writeEnable) shadow <= reg_data;
      if (ctrl_reset_n) begin
         if (reg_writeEnable || grant != '0) begin
            if (sbq.size() == 0) begin
               n_cmp++; n_bad++;
               $display("FAIL unexpected_write: cycle %0d grant %b, want no write", cyc, grant);
            end else begin
               mon_e = sbq.pop_front();
               check("write_cycle", cyc, mon_e.cyc);
               check("grant", grant, mon_e.g);
               check("ack", ack, mon_e.g);
               check("reg_data", reg_data, mon_e.d);
               check("write_count", write_count, mon_e.wc);
               check("busy", busy, 1);
            end
         end else if (sbq.size() != 0 && sbq[0].cyc <= cyc) begin
            n_cmp++; n_bad++;
            $display("FAIL missing_write: cycle %0d got no grant, want %b", cyc, sbq[0].g);
            void'(sbq.pop_front());
         end
      end
   end

   initial begin
      #1500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "timeout");
   end

   initial begin
      for (int i = 0; i < N; i++) d[i] = '0;
      drive();
      model_reset();
      cycle();
      cycle();
      // reset state
      check("rst_grant", grant, 0);
      check("rst_we", reg_writeEnable, 0);
      check("rst_busy", busy, 0);
      check("rst_data", reg_data, 0);
      check("rst_count", write_count, 0);
      ctrl_reset_n = 1'b1;

      // single request
      req = 4'b0001; d[0] = 32'hDEADBEEF; drive();
      cycle();
      req = '0;                // drop in the ack cycle
      repeat (3) cycle();
      check("single_readback", shadow, 32'hDEADBEEF);
      check("single_count", write_count, 1);

      // all contend from reset
      req = 4'b1111; lock = '0;
      for (int i = 0; i < N; i++) d[i] = $urandom;
      drive();
      do_reset();
      repeat (5) cycle();
      req = '0;
      cycle();
      check("contend_count", write_count, 5);
      drain();

      // burst limit: req0 locked, req1 waiting
      do_reset();
      req = 4'b0011; lock = 4'b0001;
      for (int t = 0; t < 12; t++) begin
         d[0] = $urandom; d[1] = $urandom; drive();
         cycle();
      end
      drain();

      // early unlock: lock2 dropped after 3 grant cycles, req3 pending
      do_reset();
      req = 4'b1100; lock = 4'b0100; d[2] = $urandom; d[3] = $urandom; drive();
      repeat (3) cycle();
      lock = '0;
      cycle();
      check("early_unlock_grant", grant, 4'b1000);
      req[3] = 1'b0;
      cycle();
      drain();

      // reset in cycle 4 of a locked burst
      do_reset();
      req = 4'b0001; lock = 4'b0001; d[0] = $urandom; drive();
      repeat (4) cycle();
      #2;
      ctrl_reset_n = 1'b0;
      model_reset();
      #1;
      check("midrst_grant", grant, 0);
      check("midrst_we", reg_writeEnable, 0);
      check("midrst_count", write_count, 0);
      req = 4'b0100; lock = '0; d[2] = $urandom; drive();
      cycle();
      ctrl_reset_n = 1'b1;
      cycle();
      check("post_rst_grant", grant, 4'b0100);
      req = '0;
      drain();

      // randomized traffic
      do_reset();
      for (int t = 0; t < 4000; t++) begin
         for (int i = 0; i < N; i++) begin
            if (m_last == i) begin
               if ($urandom_range(3) == 0) begin
                  req[i] = 1'b0; lock[i] = 1'b0;
               end else begin
                  d[i] = $urandom;
                  if ($urandom_range(7) == 0) lock[i] = ~lock[i];
               end
            end else if (!req[i]) begin
               lock[i] = 1'($urandom_range(1));   // lock without req must be ignored
               if ($urandom_range(2) == 0) begin
                  req[i] = 1'b1; d[i] = $urandom; lock[i] = ($urandom_range(2) == 0);
               end
            end else if ($urandom_range(31) == 0) begin
               req[i] = 1'b0; lock[i] = 1'b0;
            end
         end
         drive();
         cycle();
      end
      drain();

      // counter wrap
      do_reset();
      req = 4'b1111; lock = '0;
      while (m_wc < 65538) begin
         d[$urandom_range(N-1)] = $urandom; drive();
         cycle();
      end
      drain();
      check("wrap_count", write_count, 16'(m_wc));
      check("queue_empty", sbq.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
